lcd_req_arbiter: RTL and testbench



---
 rtl/lcd_req_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lcd_req_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_req_arbiter.sv
// lcd_req_arbiter: round-robin arbiter in front of one character-LCD controller.
// Each requester offers a 10-bit {rs, rw, data[7:0]} word. One winner is issued
// with a single-cycle lcd_enable pulse. Issues then pause for a settle window and
// until the controller is no longer busy.
// Optional build macro LCD_ARB_PRIO0_EN: requester 0 gets fixed top priority, and
// round-robin runs only over requesters 1..NREQ-1.
module lcd_req_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 110
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [10*NREQ-1:0]   req_bus,
    input  logic                 lcd_busy,
    output logic [NREQ-1:0]      gnt,
    output logic [2:0]           grant_id,
    output logic                 lcd_enable,
    output logic [9:0]           lcd_bus,
    output logic                 arb_busy
);

    localparam int CW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(GAP_CYCLES - 1);
    localparam logic [2:0]    LAST_RST = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CW-1:0]     cnt_r, cnt_nxt_s;
    logic [2:0]        last_r, last_nxt_s;
    logic [NREQ-1:0]   gnt_r, gnt_nxt_s;
    logic [2:0]        grant_id_r, grant_id_nxt_s;
    logic              lcd_enable_r, lcd_enable_nxt_s;
    logic [9:0]        lcd_bus_r, lcd_bus_nxt_s;
    logic              arb_busy_r, arb_busy_nxt_s;

    logic [NREQ-1:0]   cand_req_s;
    logic              hi_found_s, lo_found_s, win_found_s;
    logic [2:0]        hi_idx_s, lo_idx_s, win_idx_s;
    logic [9:0]        win_word_s;

    // Rotating-priority search: first candidate above last, else first at or below it.
    always_comb begin
        cand_req_s  = req;
`ifdef LCD_ARB_PRIO0_EN
        cand_req_s[0] = 1'b0;
`endif
        hi_found_s  = 1'b0;
        lo_found_s  = 1'b0;
        hi_idx_s    = 3'd0;
        lo_idx_s    = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand_req_s[i] && (3'(i) > last_r) && !hi_found_s) begin
                hi_found_s = 1'b1;
                hi_idx_s   = 3'(i);
            end else if (cand_req_s[i] && (3'(i) <= last_r) && !lo_found_s) begin
                lo_found_s = 1'b1;
                lo_idx_s   = 3'(i);
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        win_found_s = hi_found_s | lo_found_s;
        win_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
`ifdef LCD_ARB_PRIO0_EN
        if (req[0]) begin
            win_found_s = 1'b1;
            win_idx_s   = 3'd0;
        end else begin
            win_found_s = hi_found_s | lo_found_s;
        end
`endif
    end

    // Mux out the winner's word; only the winner's slice of req_bus is used.
    always_comb begin
        win_word_s = 10'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == win_idx_s) begin
                win_word_s = req_bus[i*10 +: 10];
            end else begin
                win_word_s = win_word_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/ISSUE/WAIT sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        last_nxt_s       = last_r;
        gnt_nxt_s        = '0;
        grant_id_nxt_s   = grant_id_r;
        lcd_enable_nxt_s = 1'b0;
        lcd_bus_nxt_s    = lcd_bus_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s && !lcd_busy) begin
                    state_nxt_s      = ST_ISSUE;
                    gnt_nxt_s        = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
                    grant_id_nxt_s   = win_idx_s;
                    lcd_enable_nxt_s = 1'b1;
                    lcd_bus_nxt_s    = win_word_s;
`ifdef LCD_ARB_PRIO0_EN
                    if (win_idx_s != 3'd0) begin
                        last_nxt_s = win_idx_s;
                    end else begin
                        last_nxt_s = last_r;
                    end
`else
                    last_nxt_s       = win_idx_s;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
                cnt_nxt_s   = '0;
            end
            ST_WAIT: begin
                if ((cnt_r == CNT_MAX) && !lcd_busy) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r != CNT_MAX) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r + CW'(1);
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
        arb_busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, counter, round-robin pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            last_r       <= LAST_RST;
            gnt_r        <= '0;
            grant_id_r   <= 3'd0;
            lcd_enable_r <= 1'b0;
            lcd_bus_r    <= 10'd0;
            arb_busy_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            last_r       <= last_nxt_s;
            gnt_r        <= gnt_nxt_s;
            grant_id_r   <= grant_id_nxt_s;
            lcd_enable_r <= lcd_enable_nxt_s;
            lcd_bus_r    <= lcd_bus_nxt_s;
            arb_busy_r   <= arb_busy_nxt_s;
        end
    end

    assign gnt        = gnt_r;
    assign grant_id   = grant_id_r;
    assign lcd_enable = lcd_enable_r;
    assign lcd_bus    = lcd_bus_r;
    assign arb_busy   = arb_busy_r;

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// tb_lcd_req_arbiter: directed-vector bench for lcd_req_arbiter (NREQ=4, GAP_CYCLES=4).
module tb_lcd_req_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] req_bus;
    logic        lcd_busy;
    logic [3:0]  gnt;
    logic [2:0]  grant_id;
    logic        lcd_enable;
    logic [9:0]  lcd_bus;
    logic        arb_busy;

    int total;
    int bad;

    localparam logic [9:0] W0 = 10'h100;
    localparam logic [9:0] W1 = 10'h241;
    localparam logic [9:0] W2 = 10'h0A2;
    localparam logic [9:0] W3 = 10'h3C3;

    lcd_req_arbiter #(.NREQ(4), .GAP_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_bus    (req_bus),
        .lcd_busy   (lcd_busy),
        .gnt        (gnt),
        .grant_id   (grant_id),
        .lcd_enable (lcd_enable),
        .lcd_bus    (lcd_bus),
        .arb_busy   (arb_busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return one << k;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (arb_busy == 1'b0) break;
            tick();
        end
        chk("idle_timeout", 32'(arb_busy), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        req_bus  = {W3, W2, W1, W0};
        lcd_busy = 1'b0;
        req      = 4'b1111;
        rst      = 1'b1;

        // Reset held 3 cycles with all requests up: every output stays 0.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_id", 32'(grant_id), 32'd0);
            chk("rst_en", 32'(lcd_enable), 32'd0);
            chk("rst_bus", 32'(lcd_bus), 32'd0);
            chk("rst_abusy", 32'(arb_busy), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt), 32'(4'b0001));
        chk("first_en", 32'(lcd_enable), 32'd1);
        chk("first_bus", 32'(lcd_bus), 32'(W0));
        req = 4'b0000;
        wait_idle();

        // Single word from requester 1.
        req = 4'b0010;
        tick();
        chk("sw_en", 32'(lcd_enable), 32'd1);
        chk("sw_gnt", 32'(gnt), 32'(4'b0010));
        chk("sw_id", 32'(grant_id), 32'd1);
        chk("sw_bus", 32'(lcd_bus), 32'(W1));
        chk("sw_abusy0", 32'(arb_busy), 32'd1);
        req = 4'b0000;
        for (int c = 1; c < 5; c++) begin
            tick();
            chk("sw_abusy", 32'(arb_busy), 32'd1);
            chk("sw_en_low", 32'(lcd_enable), 32'd0);
            chk("sw_gnt_low", 32'(gnt), 32'd0);
        end
        tick();
        chk("sw_abusy_end", 32'(arb_busy), 32'd0);
        chk("sw_bus_hold", 32'(lcd_bus), 32'(W1));

        // Fairness after a fresh reset: grants 0,1,2,3,0 spaced 6 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        chk("fair_gnt0", 32'(gnt), 32'(4'b0001));
        chk("fair_en0", 32'(lcd_enable), 32'd1);
        for (int k = 1; k < 5; k++) begin
            for (int c = 0; c < 5; c++) begin
                tick();
                chk("fair_gap", 32'(lcd_enable), 32'd0);
            end
            tick();
            chk("fair_gnt", 32'(gnt), 32'(onehot(k % 4)));
            chk("fair_id", 32'(grant_id), 32'(k % 4));
            chk("fair_en", 32'(lcd_enable), 32'd1);
        end

        // Busy stretch: lcd_busy high for 10 cycles starting one cycle after ISSUE.
        tick();
        lcd_busy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("bs_abusy", 32'(arb_busy), 32'd1);
            chk("bs_en", 32'(lcd_enable), 32'd0);
            tick();
        end
        lcd_busy = 1'b0;
        chk("bs_abusy_last", 32'(arb_busy), 32'd1);
        tick();
        chk("bs_idle", 32'(arb_busy), 32'd0);
        chk("bs_en_early", 32'(lcd_enable), 32'd0);
        tick();
        chk("bs_en_next", 32'(lcd_enable), 32'd1);
        chk("bs_gnt", 32'(gnt), 32'(4'b0010));
        req = 4'b0000;
        wait_idle();

        // Busy while idle blocks arbitration; grant follows one cycle after release.
        lcd_busy = 1'b1;
        req      = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bi_gnt", 32'(gnt), 32'd0);
            chk("bi_abusy", 32'(arb_busy), 32'd0);
        end
        lcd_busy = 1'b0;
        tick();
        chk("bi_gnt_rel", 32'(gnt), 32'(4'b0100));
        chk("bi_id", 32'(grant_id), 32'd2);
        chk("bi_bus", 32'(lcd_bus), 32'(W2));
        req = 4'b0000;

        // Reset at cnt=2 of WAIT, then requests 0 and 2 held.
        tick();
        tick();
        tick();
        chk("rw_abusy_pre", 32'(arb_busy), 32'd1);
        rst = 1'b1;
        req = 4'b0101;
        tick();
        chk("rw_abusy", 32'(arb_busy), 32'd0);
        chk("rw_gnt", 32'(gnt), 32'd0);
        chk("rw_bus", 32'(lcd_bus), 32'd0);
        rst = 1'b0;
        tick();
        chk("rw_gnt0", 32'(gnt), 32'(4'b0001));
        for (int k = 1; k < 3; k++) begin
            for (int c = 0; c < 5; c++) begin
                tick();
            end
            tick();
`ifdef LCD_ARB_PRIO0_EN
            chk("prio_gnt", 32'(gnt), 32'(4'b0001));
`else
            chk("rr_gnt", 32'(gnt), 32'((k == 1) ? 4'b0100 : 4'b0001));
`endif
        end
        req = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
